// File: rtl/math_sin_range_reduce.sv
// math_sin_range_reduce: elastic pipelined argument reduction ahead of a
// floating-point sine unit. Produces r = x - k*2pi with k = rne(x/2pi).
//
// Ports:
//   clk, rst                  clock, synchronous active-high reset
//   a_valid/a_ready/a_data    operand in (IEEE-754 bits, WIDTH = 32 or 64)
//   result_valid/result_ready/result_data   reduced operand out, |r| <= pi
//
// Arithmetic is behavioural (real). Single precision is widened to double
// and narrowed back with explicit IEEE bit handling (round to nearest
// even), so the result does not depend on how a simulator models
// shortreal. Inputs with |x| <= pi are forwarded bit-exact, NaN/Inf
// produce the canonical quiet NaN.
module math_sin_range_reduce #(
    parameter int WIDTH   = 32,
    parameter int LATENCY = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             a_valid,
    output logic             a_ready,
    input  logic [WIDTH-1:0] a_data,
    output logic             result_valid,
    input  logic             result_ready,
    output logic [WIDTH-1:0] result_data
);

    if (WIDTH != 32 && WIDTH != 64) begin : g_bad_width
        $fatal(1, "math_sin_range_reduce: WIDTH must be 32 or 64");
    end

    if (LATENCY < 1 || LATENCY > 8) begin : g_bad_latency
        $fatal(1, "math_sin_range_reduce: LATENCY must be 1..8");
    end

    localparam real TWO_PI = 6.283185307179586;
    localparam real PI     = 3.141592653589793;

    // Largest magnitudes (sign bit stripped) that still satisfy |x| <= pi.
    localparam logic [30:0] PI32_MAG = 31'h40490FDA;
    localparam logic [62:0] PI64_MAG = 63'h400921FB54442D18;

    localparam logic [31:0] QNAN32 = 32'h7FC00000;
    localparam logic [63:0] QNAN64 = 64'h7FF8000000000000;

    // ------------------------------------------------------------------
    // Arithmetic
    // ------------------------------------------------------------------

    // r = x - k*2pi, k rounded to nearest with ties to even, then clamped
    // so that rounding in the subtraction can never push |r| past pi.
    function automatic real wrap_2pi(input real x);
        real q;
        real f;
        real k;
        real r;
        q = x / TWO_PI;
        f = $floor(q);
        if (q - f > 0.5) begin
            k = f + 1.0;
        end else if (q - f < 0.5) begin
            k = f;
        end else if ($floor(f / 2.0) * 2.0 == f) begin
            k = f;
        end else begin
            k = f + 1.0;
        end
        r = x - k * TWO_PI;
        if (r > PI) begin
            r = PI;
        end else if (r < -PI) begin
            r = -PI;
        end
        return r;
    endfunction

    // Normal single -> double bits. Only called for |x| > pi, so the
    // operand is always a normal number.
    function automatic logic [63:0] widen32(input logic [31:0] b);
        logic [10:0] e;
        e = {3'b000, b[30:23]} + 11'd896;
        return {b[31], e, b[22:0], 29'd0};
    endfunction

    // Double -> single bits, round to nearest even. The value is already
    // bounded by pi, so overflow cannot occur; anything below the single
    // normal range is flushed to a signed zero.
    function automatic logic [31:0] narrow64(input logic [63:0] d);
        logic [7:0]  e8;
        logic [30:0] mag;
        logic        rnd;
        if (d[62:52] < 11'd897) begin
            return {d[63], 31'd0};
        end
        // (e - 896) mod 256 == e[7:0] + 128
        e8  = {~d[59], d[58:52]};
        mag = {e8, d[51:29]};
        rnd = d[28] & ((|d[27:0]) | d[29]);
        mag = mag + {30'd0, rnd};
        return {d[63], mag};
    endfunction

    function automatic logic [31:0] reduce32(input logic [31:0] b);
        real x;
        if (b[30:23] == 8'hFF) begin
            return QNAN32;
        end
        if (b[30:0] <= PI32_MAG) begin
            return b;
        end
        x = $bitstoreal(widen32(b));
        return narrow64($realtobits(wrap_2pi(x)));
    endfunction

    function automatic logic [63:0] reduce64(input logic [63:0] b);
        if (b[62:52] == 11'h7FF) begin
            return QNAN64;
        end
        if (b[62:0] <= PI64_MAG) begin
            return b;
        end
        return $realtobits(wrap_2pi($bitstoreal(b)));
    endfunction

    logic [WIDTH-1:0] reduced;

    if (WIDTH == 64) begin : g_w64
        assign reduced = reduce64(a_data);
    end else begin : g_w32
        assign reduced = reduce32(a_data);
    end

    // ------------------------------------------------------------------
    // Elastic pipeline
    // ------------------------------------------------------------------

    logic [LATENCY-1:0] valid;
    logic [LATENCY-1:0] advance;
    logic [WIDTH-1:0]   data [LATENCY];
    logic               take;

    // A stage may move when it or any stage after it is empty, or when
    // the consumer takes the head. This is the closed form of the
    // ripple !valid[i] | advance[i+1], so bubbles collapse.
    for (genvar i = 0; i < LATENCY; i++) begin : g_adv
        assign advance[i] = ~(&valid[LATENCY-1:i]) | result_ready;
    end

    assign a_ready = advance[0] & ~rst;
    assign take    = a_valid & a_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            valid[0] <= 1'b0;
        end else if (advance[0]) begin
            valid[0] <= take;
        end
    end

    always_ff @(posedge clk) begin
        if (advance[0] && take) begin
            data[0] <= reduced;
        end
    end

    for (genvar i = 1; i < LATENCY; i++) begin : g_stage
        always_ff @(posedge clk) begin
            if (rst) begin
                valid[i] <= 1'b0;
            end else if (advance[i]) begin
                valid[i] <= valid[i-1];
            end
        end

        always_ff @(posedge clk) begin
            if (advance[i]) begin
                data[i] <= data[i-1];
            end
        end
    end

    // The head is masked during reset so nothing in flight escapes in the
    // cycle the reset is first seen.
    assign result_valid = valid[LATENCY-1] & ~rst;
    assign result_data  = data[LATENCY-1];

endmodule

// File: tb/tb_math_sin_range_reduce.sv
// Bench for math_sin_range_reduce: vector table, backpressure, random
// stream against a real-arithmetic reference, mid-stream reset, 64-bit.
module tb_math_sin_range_reduce;

    localparam int  L32    = 2;
    localparam int  L64    = 3;
    localparam real TWO_PI = 6.283185307179586;
    localparam real PI     = 3.141592653589793;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        a_valid;
    logic        a_ready;
    logic [31:0] a_data;
    logic        result_valid;
    logic        result_ready;
    logic [31:0] result_data;

    logic        a_valid64;
    logic        a_ready64;
    logic [63:0] a_data64;
    logic        result_valid64;
    logic        result_ready64;
    logic [63:0] result_data64;

    math_sin_range_reduce #(.WIDTH(32), .LATENCY(L32)) u_dut (
        .clk          (clk),
        .rst          (rst),
        .a_valid      (a_valid),
        .a_ready      (a_ready),
        .a_data       (a_data),
        .result_valid (result_valid),
        .result_ready (result_ready),
        .result_data  (result_data)
    );

    math_sin_range_reduce #(.WIDTH(64), .LATENCY(L64)) u_dut64 (
        .clk          (clk),
        .rst          (rst),
        .a_valid      (a_valid64),
        .a_ready      (a_ready64),
        .a_data       (a_data64),
        .result_valid (result_valid64),
        .result_ready (result_ready64),
        .result_data  (result_data64)
    );

    int checks   = 0;
    int failures = 0;

    // ---------------- reference ----------------

    function automatic real rabs(input real v);
        return (v < 0.0) ? -v : v;
    endfunction

    function automatic real dec32(input logic [31:0] b);
        real v;
        int  e;
        e = int'(b[30:23]);
        if (e == 0) v = real'(b[22:0]) * (2.0 ** -149.0);
        else v = (1.0 + real'(b[22:0]) / 8388608.0) * (2.0 ** real'(e - 127));
        return b[31] ? -v : v;
    endfunction

    function automatic real model_r(input real x);
        real q;
        real k;
        real r;
        q = x / TWO_PI;
        k = $floor(q + 0.5);
        if (k - q == 0.5 && $floor(k / 2.0) * 2.0 != k) k = k - 1.0;
        r = x - k * TWO_PI;
        if (r > PI) r = PI;
        if (r < -PI) r = -PI;
        return r;
    endfunction

    task automatic expect_bits(input string name, input logic [63:0] got,
                               input logic [63:0] need);
        checks++;
        if (got !== need) begin
            failures++;
            $display("FAIL %s: got %h required %h", name, got, need);
        end
    endtask

    task automatic expect_near(input string name, input real got,
                               input real need, input real tol);
        checks++;
        if (!(rabs(got - need) <= tol)) begin
            failures++;
            $display("FAIL %s: got %.10g required %.10g tol %g",
                     name, got, need, tol);
        end
    endtask

    task automatic check32(input string name, input logic [31:0] din,
                           input logic [31:0] got);
        real x;
        real r;
        real g;
        real tol;
        if (din[30:23] == 8'hFF) begin
            expect_bits(name, {32'd0, got}, 64'h7FC00000);
        end else begin
            x = dec32(din);
            if (rabs(x) <= PI) begin
                expect_bits(name, {32'd0, got}, {32'd0, din});
            end else begin
                r   = model_r(x);
                g   = dec32(got);
                tol = rabs(r) * (2.0 ** -23.0);
                expect_near(name, g, r, tol);
                expect_bits({name, "_range"},
                            {63'd0, rabs(g) <= PI + tol}, 64'd1);
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // ---------------- stream scoreboard ----------------

    logic [31:0] sb_q[$];
    bit          sb_on  = 1'b0;
    int          n_out  = 0;
    bit          held_v = 1'b0;
    logic [31:0] held_d;

    always @(negedge clk) begin
        if (sb_on) begin
            if (held_v && result_valid)
                expect_bits("hold", {32'd0, result_data}, {32'd0, held_d});
            held_v = result_valid && !result_ready;
            held_d = result_data;
            if (a_valid && a_ready) sb_q.push_back(a_data);
            if (result_valid && result_ready) begin
                n_out++;
                if (sb_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL extra_result: got %h required none",
                             result_data);
                end else begin
                    check32("stream", sb_q.pop_front(), result_data);
                end
            end
        end else begin
            held_v = 1'b0;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout required finish");
        $fatal(1, "timeout");
    end

    // ---------------- vectors ----------------

    typedef struct {
        logic [31:0] din;
        bit          exact;
        logic [31:0] exp_bits;
        real         exp_val;
        real         tol;
    } vec_t;

    vec_t        vecs[11];
    logic [31:0] ops[8];
    int          idx;
    int          cyc;
    int          drops;
    int          gaps;
    int          seen;
    bit          acc;
    bit          saw_stall;
    int          e;

    function automatic logic [31:0] rand_finite();
        logic [31:0] m;
        logic [7:0]  ex;
        m  = $urandom;
        ex = 8'($urandom_range(100, 150));
        return {1'($urandom_range(0, 1)), ex, m[22:0]};
    endfunction

    initial begin
        vecs[0]  = '{32'h40E00000, 1'b0, 32'h0, 0.7168146928204138, 6.0e-8};
        vecs[1]  = '{32'hC0E00000, 1'b0, 32'h0, -0.7168146928204138, 6.0e-8};
        vecs[2]  = '{32'h3F800000, 1'b1, 32'h3F800000, 0.0, 0.0};
        vecs[3]  = '{32'h80000000, 1'b1, 32'h80000000, 0.0, 0.0};
        vecs[4]  = '{32'h7F800000, 1'b1, 32'h7FC00000, 0.0, 0.0};
        vecs[5]  = '{32'h7FC00001, 1'b1, 32'h7FC00000, 0.0, 0.0};
        vecs[6]  = '{32'h461C4000, 1'b0, 32'h0, -2.8310090299, 1.0e-3};
        vecs[7]  = '{32'h00000001, 1'b1, 32'h00000001, 0.0, 0.0};
        vecs[8]  = '{32'hFF800000, 1'b1, 32'h7FC00000, 0.0, 0.0};
        vecs[9]  = '{32'h40490FDA, 1'b1, 32'h40490FDA, 0.0, 0.0};
        vecs[10] = '{32'h40490FDB, 1'b0, 32'h0, -3.141592566167013, 3.0e-7};

        rst            = 1'b1;
        a_valid        = 1'b1;
        a_data         = 32'h3F800000;
        result_ready   = 1'b1;
        a_valid64      = 1'b0;
        a_data64       = 64'd0;
        result_ready64 = 1'b1;

        // reset with a_valid held high
        for (int i = 0; i < 3; i++) begin
            tick();
            expect_bits("rst_a_ready", {63'd0, a_ready}, 64'd0);
            expect_bits("rst_result_valid", {63'd0, result_valid}, 64'd0);
            expect_bits("rst_result_valid64", {63'd0, result_valid64}, 64'd0);
        end
        rst     = 1'b0;
        a_valid = 1'b0;
        tick();
        expect_bits("post_rst_a_ready", {63'd0, a_ready}, 64'd1);
        expect_bits("post_rst_idle", {63'd0, result_valid}, 64'd0);

        // table: one operand at a time, exact latency
        for (int i = 0; i < 11; i++) begin
            a_valid = 1'b1;
            a_data  = vecs[i].din;
            #1;
            expect_bits("vec_accept", {63'd0, a_ready}, 64'd1);
            tick();
            a_valid = 1'b0;
            for (int n = 1; n < L32; n++) begin
                expect_bits("vec_early", {63'd0, result_valid}, 64'd0);
                tick();
            end
            expect_bits("vec_valid", {63'd0, result_valid}, 64'd1);
            if (vecs[i].exact)
                expect_bits("vec_bits", {32'd0, result_data},
                            {32'd0, vecs[i].exp_bits});
            else
                expect_near("vec_val", dec32(result_data),
                            vecs[i].exp_val, vecs[i].tol);
            tick();
        end

        // backpressure: 1.0..8.0, consumer stalled in cycles 3..9
        ops = '{32'h3F800000, 32'h40000000, 32'h40400000, 32'h40800000,
                32'h40A00000, 32'h40C00000, 32'h40E00000, 32'h41000000};
        sb_on     = 1'b1;
        n_out     = 0;
        idx       = 0;
        cyc       = 0;
        saw_stall = 1'b0;
        while (idx < 8 && cyc < 100) begin
            result_ready = !(cyc >= 3 && cyc <= 9);
            a_valid      = 1'b1;
            a_data       = ops[idx];
            #1;
            acc = a_ready;
            if (!a_ready) saw_stall = 1'b1;
            tick();
            if (acc) idx++;
            cyc++;
        end
        a_valid = 1'b0;
        while (n_out < 8 && cyc < 100) begin
            result_ready = !(cyc >= 3 && cyc <= 9);
            tick();
            cyc++;
        end
        result_ready = 1'b1;
        tick();
        tick();
        expect_bits("bp_in", idx, 8);
        expect_bits("bp_out", n_out, 8);
        expect_bits("bp_queue", sb_q.size(), 0);
        expect_bits("bp_a_ready_drop", {63'd0, saw_stall}, 64'd1);
        expect_bits("bp_no_dup", {63'd0, result_valid}, 64'd0);

        // random full-throughput stream
        n_out = 0;
        drops = 0;
        gaps  = 0;
        for (int i = 0; i < 100; i++) begin
            a_valid = 1'b1;
            a_data  = rand_finite();
            #1;
            if (!a_ready) drops++;
            if (i >= L32 && !result_valid) gaps++;
            tick();
        end
        a_valid = 1'b0;
        for (int i = 0; i < 20 && n_out < 100; i++) tick();
        expect_bits("rnd_drops", drops, 0);
        expect_bits("rnd_gaps", gaps, 0);
        expect_bits("rnd_count", n_out, 100);
        expect_bits("rnd_queue", sb_q.size(), 0);
        sb_on = 1'b0;
        tick();

        // reset with two operands in flight
        a_valid = 1'b1;
        a_data  = 32'h40E00000;
        tick();
        a_data = 32'h40800000;
        tick();
        a_valid = 1'b0;
        rst     = 1'b1;
        #1;
        seen = 0;
        if (result_valid) seen++;
        expect_bits("mid_rst_a_ready", {63'd0, a_ready}, 64'd0);
        tick();
        rst = 1'b0;
        for (int i = 0; i < 2; i++) begin
            if (result_valid) seen++;
            tick();
        end
        expect_bits("mid_rst_discard", seen, 0);
        a_valid = 1'b1;
        a_data  = 32'h3F800000;
        #1;
        expect_bits("mid_rst_accept", {63'd0, a_ready}, 64'd1);
        tick();
        a_valid = 1'b0;
        for (int n = 1; n < L32; n++) begin
            expect_bits("mid_rst_early", {63'd0, result_valid}, 64'd0);
            tick();
        end
        expect_bits("mid_rst_valid", {63'd0, result_valid}, 64'd1);
        expect_bits("mid_rst_data", {32'd0, result_data}, 64'h3F800000);
        tick();

        // 64-bit instance
        for (int v = 0; v < 3; v++) begin
            a_valid64 = 1'b1;
            a_data64  = (v == 0) ? 64'h401C000000000000 :
                        (v == 1) ? 64'h7FF0000000000000 :
                                   64'h8000000000000000;
            #1;
            expect_bits("w64_accept", {63'd0, a_ready64}, 64'd1);
            tick();
            a_valid64 = 1'b0;
            for (int n = 1; n < L64; n++) begin
                expect_bits("w64_early", {63'd0, result_valid64}, 64'd0);
                tick();
            end
            expect_bits("w64_valid", {63'd0, result_valid64}, 64'd1);
            if (v == 0)
                expect_near("w64_val", $bitstoreal(result_data64),
                            0.7168146928204138, 1.2e-16);
            else if (v == 1)
                expect_bits("w64_nan", result_data64, 64'h7FF8000000000000);
            else
                expect_bits("w64_negzero", result_data64, 64'h8000000000000000);
            tick();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
